if_id_queue: RTL

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/if_id_queue_pkg.sv | 13 +
 rtl/if_id_queue_mem.sv | 26 ++
 rtl/if_id_queue.sv | 99 +++++++++
 3 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared constants and the fetch->decode entry bundle.
// Used by the queue top and its storage sub-module.
package if_id_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// DEPTH x 64-bit entry storage for the IF/ID queue.
// One synchronous write port, one asynchronous read port.
module if_id_queue_mem
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  if_id_t        wdata,
  input  logic [AW-1:0] raddr,
  output if_id_t        rdata
);

  if_id_t mem [DEPTH];

  // write the pushed entry; storage is never reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: FIFO of fetched {pc, instruction} pairs.
// Define IF_ID_QUEUE_PERF_EN to add starve_cnt / full_cnt counters.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [31:0]            in_pc,
  input  logic [31:0]            in_instruction,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_instruction,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
`ifdef IF_ID_QUEUE_PERF_EN
  ,
  output logic [31:0]            starve_cnt,
  output logic [31:0]            full_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  if_id_t        wdata;
  if_id_t        rdata;

  assign in_ready  = count < FULL;
  assign out_valid = count != '0;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign wdata.pc    = in_pc;
  assign wdata.instr = in_instruction;

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // empty queue presents a bubble to decode
  always_comb begin
    out_pc          = '0;
    out_instruction = NOP_INSTR;
    if (out_valid) begin
      out_pc          = rdata.pc;
      out_instruction = rdata.instr;
    end
  end

`ifdef IF_ID_QUEUE_PERF_EN
  // saturating stall counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      full_cnt   <= '0;
    end else begin
      if (out_ready && !out_valid && starve_cnt != '1)
        starve_cnt <= starve_cnt + 1'b1;
      if (in_valid && !in_ready && full_cnt != '1)
        full_cnt <= full_cnt + 1'b1;
    end
  end
`endif

endmodule
